// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock on a single 128-bit state.
// Nr is chosen per block (AES-128/192/256); round keys are fetched by index from an external store.
module aes_inv_cipher_iter #(
  parameter int unsigned MAX_NR = 14,
  parameter int unsigned IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [1:0]       key_len,
  output logic [IDX_W-1:0] rk_idx,
  input  logic [127:0]     rk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WHITEN = 2'd1;
  localparam logic [1:0] S_ROUND  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (row, col) sits at index row + 4*col; row r is rotated right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned row = 0; row < 4; row++)
        r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + 4 - row) % 4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++)
      r[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a, m2, m4, m8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int unsigned i = 0; i < 4; i++) begin
      a     = col[31 - 8*i -: 8];
      m2    = xtime(a);
      m4    = xtime(m2);
      m8    = xtime(m4);
      m9[i] = m8 ^ a;
      mb[i] = m8 ^ m2 ^ a;
      md[i] = m8 ^ m4 ^ a;
      me[i] = m8 ^ m4 ^ m2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++)
      r[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [127:0]     st_q, st_d;
  logic [IDX_W-1:0] nr_q, nr_d;
  logic [IDX_W-1:0] rnd_q, rnd_d;
  logic             err_q, err_d;

  logic [127:0]     ark;
  logic [127:0]     imc;
  logic [4:0]       nr_sel;
  logic             key_ok;

  always_comb begin
    ark = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_data;
    imc = inv_mix_columns(ark);
  end

  always_comb begin
    case (key_len)
      2'd0:    nr_sel = 5'd10;
      2'd1:    nr_sel = 5'd12;
      2'd2:    nr_sel = 5'd14;
      default: nr_sel = 5'd0;
    endcase
    key_ok = (key_len != 2'd3) && (32'(nr_sel) <= MAX_NR);
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    nr_d    = nr_q;
    rnd_d   = rnd_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (key_ok) begin
            st_d    = in_data;
            nr_d    = IDX_W'(nr_sel);
            rnd_d   = IDX_W'(nr_sel);
            state_d = S_WHITEN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WHITEN: begin
        st_d    = st_q ^ rk_data;
        rnd_d   = nr_q - 1'b1;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (rnd_q != '0) begin
          st_d  = imc;
          rnd_d = rnd_q - 1'b1;
        end else begin
          st_d    = ark;
          state_d = S_DONE;
        end
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      nr_q    <= '0;
      rnd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      nr_q    <= nr_d;
      rnd_q   <= rnd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    case (state_q)
      S_WHITEN: rk_idx = nr_q;
      S_ROUND:  rk_idx = rnd_q;
      default:  rk_idx = '0;
    endcase
  end

  // in_ready is also held low while reset is asserted.
  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_valid ? st_q : '0;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: forward-AES reference model with key expansion,
// scoreboard of expected plaintexts, FIPS-197 vectors plus random AES-256 blocks.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [127:0] in_data;
  logic [1:0]   key_len;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         err;

  logic         in_valid1, in_ready1;
  logic [127:0] in_data1;
  logic [1:0]   key_len1;
  logic [3:0]   rk_idx1;
  logic [127:0] rk_data1;
  logic         out_valid1, out_ready1;
  logic [127:0] out_data1;
  logic         err1;

  logic [127:0] rk_tab [16];
  logic [7:0]   fsbox [256];

  typedef struct {
    logic [127:0] pt;
    int unsigned  lat;
    int unsigned  acc;
  } exp_t;
  exp_t sb [$];

  int unsigned cyc = 0;
  int unsigned last_hs = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          ov_seen = 1'b0;

  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C2_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rk_data  = rk_tab[rk_idx];
  assign rk_data1 = rk_tab[rk_idx1];

  aes_inv_cipher_iter #(.MAX_NR(14), .IDX_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .key_len(key_len),
    .rk_idx(rk_idx), .rk_data(rk_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err(err)
  );

  aes_inv_cipher_iter #(.MAX_NR(10), .IDX_W(4)) u_dut10 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .key_len(key_len1),
    .rk_idx(rk_idx1), .rk_data(rk_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .err(err1)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] v);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (v != 8'h00 && gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {fsbox[w[31:24]], fsbox[w[23:16]], fsbox[w[15:8]], fsbox[w[7:0]]};
  endfunction

  task automatic load_key(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] k, res;
    k = rk_tab[0];
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[w + 4*c] = fsbox[s[w + 4*((c + w) % 4)]];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end
      end else begin
        s = t;
      end
      k = rk_tab[r];
      for (int i = 0; i < 16; i++) s[i] ^= k[127 - 8*i -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // Output monitor: on each rising out_valid pop the scoreboard and check data and latency.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !out_valid) ov_seen = 1'b0;
    else if (!ov_seen) begin
      ov_seen = 1'b1;
      if (sb.size() == 0) check("spurious_out", 128'(out_valid), 128'(0));
      else begin
        e = sb.pop_front();
        check("pt", out_data, e.pt);
        check("latency", 128'(cyc - e.acc), 128'(e.lat));
      end
    end
    if (rst_n && out_valid && out_ready) last_hs = cyc + 1;
  end

  task automatic send(input logic [127:0] ct, input logic [1:0] kl, input logic [127:0] pt,
                      input int unsigned lat, input bit hold, output int unsigned acc);
    int unsigned n;
    exp_t e;
    n = 0;
    acc = 0;
    in_data  = ct;
    key_len  = kl;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 128'(in_ready), 128'(1));
      in_valid = 1'b0;
      return;
    end
    acc   = cyc + 1;
    e.pt  = pt;
    e.lat = lat;
    e.acc = acc;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_sb", 128'(sb.size()), 128'(0));
    check("drain_ready", 128'(in_ready), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc, n;
    logic [127:0] pt, ct;
    logic [255:0] key;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; key_len = 2'd0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; key_len1 = 2'd0; out_ready1 = 1'b1;
    for (int i = 0; i < 256; i++) fsbox[i] = sbox_calc(8'(i));
    for (int i = 0; i < 16; i++) rk_tab[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    check("rst_rk_idx", 128'(rk_idx), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 128'(in_ready), 128'(1));

    // AES-128 FIPS-197 C.1 with round-key index sequence
    load_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    send(C1_CT, 2'd0, FIPS_PT, 11, 1'b0, acc);
    for (int k = 0; k <= 10; k++) begin
      check("rk_idx", 128'(rk_idx), 128'(10 - k));
      @(negedge clk);
    end
    drain();

    load_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    send(C2_CT, 2'd1, FIPS_PT, 13, 1'b0, acc);
    drain();

    load_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    send(C3_CT, 2'd2, FIPS_PT, 15, 1'b0, acc);
    drain();

    // Backpressure
    load_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    out_ready = 1'b0;
    send(C1_CT, 2'd0, FIPS_PT, 11, 1'b0, acc);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", 128'(out_valid), 128'(1));
    for (int k = 0; k < 20; k++) begin
      check("bp_data", out_data, FIPS_PT);
      check("bp_in_ready", 128'(in_ready), 128'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 128'(out_valid), 128'(0));
    check("bp_release_ready", 128'(in_ready), 128'(1));

    // Illegal key_len
    in_data = C1_CT; key_len = 2'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("ill_err", 128'(err), 128'(1));
    check("ill_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    check("ill_err_pulse", 128'(err), 128'(0));
    repeat (15) @(negedge clk);
    check("ill_no_out", 128'(out_valid), 128'(0));
    check("ill_ready_after", 128'(in_ready), 128'(1));

    // Nr above MAX_NR on the MAX_NR=10 instance
    in_data1 = C3_CT; key_len1 = 2'd2; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    check("max_err", 128'(err1), 128'(1));
    check("max_in_ready", 128'(in_ready1), 128'(1));
    @(negedge clk);
    check("max_err_pulse", 128'(err1), 128'(0));
    repeat (16) @(negedge clk);
    check("max_no_out", 128'(out_valid1), 128'(0));
    check("max_out_data", out_data1, 128'(0));

    // Reset in the middle of an AES-128 block
    send(C1_CT, 2'd0, FIPS_PT, 11, 1'b0, acc);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    for (int k = 0; k < 20; k++) begin
      check("midrst_no_out", 128'(out_valid), 128'(0));
      @(negedge clk);
    end
    send(C1_CT, 2'd0, FIPS_PT, 11, 1'b0, acc);
    drain();

    // Back-to-back random AES-256 blocks with in_valid held high
    key = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
    load_key(key, 8);
    for (int b = 0; b < 4; b++) begin
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      ct = encrypt(pt, 14);
      send(ct, 2'd2, pt, 15, 1'b1, acc);
      if (b > 0) check("b2b_gap", 128'(acc - last_hs), 128'(1));
    end
    in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
Iterative, multi-key-length AES inverse cipher. It runs one inverse round per clock on a single 128-bit state register and reuses the existing inv_shift_rows, inv_subbytes, inv_add_round_keys and inv_Mix_Column blocks. Supersedes the purely combinational single-round usage: it adds round sequencing, a selectable round count for AES-128/192/256, round-key indexing and valid/ready handshakes. Sits between the block-input buffer and the plaintext output stage. Round keys come from an external key-schedule store.

Parameters:
MAX_NR, 14, largest round count accepted (10, 12 or 14); key_len codes whose Nr exceeds MAX_NR are rejected
IDX_W, 4, width of rk_idx; must satisfy 2^IDX_W > MAX_NR

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous reset, active low
in_valid  in  1  ciphertext block offered
in_ready  out  1  block accepted when in_valid & in_ready
in_data  in  128  ciphertext; [127:120] = state byte 0, same ordering as the round submodules
key_len  in  2  sampled on accept: 0 -> Nr=10, 1 -> Nr=12, 2 -> Nr=14, 3 -> illegal
rk_idx  out  IDX_W  index of the round key required this cycle
rk_data  in  128  round key rk[rk_idx]; combinational store, valid in the same cycle
out_valid  out  1  plaintext available
out_ready  in  1  downstream accepts when out_valid & out_ready
out_data  out  128  plaintext
err  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, in_ready=0 during reset, out_valid=0, err=0, out_data=0, rk_idx=0, round counter=0. Reset mid-operation abandons the block with no output.
- Required in_ready = (state==IDLE). There is no overlap: one block in flight at a time.
- Accept edge (E0) in IDLE with in_valid=1:
  - key_len legal and Nr<=MAX_NR: latch in_data into st, latch Nr, rnd<=Nr, go to WHITEN.
  - Otherwise: err=1 for the next cycle, block is dropped, stay in IDLE (in_ready stays 1).
- WHITEN (1 cycle): rk_idx=Nr; st<=st^rk_data; rnd<=Nr-1; go to ROUND.
- ROUND: rk_idx=rnd.
  - If rnd!=0: st<=InvMixColumns(InvSubBytes(InvShiftRows(st))^rk_data); rnd<=rnd-1.
  - If rnd==0 (last round): st<=InvSubBytes(InvShiftRows(st))^rk_data, with no InvMixColumns; go to DONE.
- Latency: out_valid rises after edge E0+Nr+1. AES-128 takes 11 cycles, AES-192 13, AES-256 15.
- DONE: out_valid=1 and out_data=st, both held stable while out_ready=0. On the handshake edge: out_valid<=0, go to IDLE, in_ready=1 next cycle. A new block cannot be accepted in the same cycle as the output handshake.
- rk_idx in IDLE/DONE is 0 and don't-care to the key store. rk_data is sampled only in WHITEN/ROUND.
- in_valid or key_len changes while busy are ignored. out_ready while not out_valid is ignored.
- Round count is decided by the latched Nr only. rnd never wraps below 0.
- err is registered and never coincides with a state change out of IDLE.

Test Plan:
- FIPS-197 C.1 AES-128: bench supplies rk[0..10] for key 000102030405060708090a0b0c0d0e0f. Input ct 69c4e0d86a7b0430d8cdb78070b4c55a, key_len=0 -> out_data 00112233445566778899aabbccddeeff with out_valid exactly 11 cycles after accept. rk_idx sequence: 10, 9, …, 0.
- AES-192 (key 00..17, key_len=1): ct dda97ca4864cdfe06eaf70a0ec0d7191 -> 00112233445566778899aabbccddeeff after 13 cycles. AES-256 (key 00..1f, key_len=2): ct 8ea2b7ca516745bfeafc49904b496089 -> same pt after 15 cycles.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data stable and in_ready=0 throughout. out_ready=1 for 1 cycle -> out_valid=0 and in_ready=1 on the next cycle.
- Illegal mode: key_len=3 with in_valid=1 -> err pulses for exactly 1 cycle, no out_valid, in_ready stays 1. Repeat with MAX_NR=10 and key_len=2 -> same rejection.
- Reset mid-block: drop rst_n for 1 cycle at round 5 of an AES-128 block -> out_valid=0 and no output ever appears for that block. The next C.1 block decrypts correctly in 11 cycles.
- Back-to-back: 4 random blocks against a reference model with in_valid held high and out_ready=1 -> each accepted 1 cycle after the previous output handshake, all outputs match the model.
